// File: rtl/wb_bram_waitstate_ctrl.sv
// Wishbone slave word memory with programmable read/write wait states,
// a small CSR window (CTRL, ERRCNT, DEPTH) and out-of-range error reporting.
module wb_bram_waitstate_ctrl #(
  parameter logic [11:0] BASE_ADDR   = 12'h380,
  parameter int          DEPTH       = 1024,
  parameter int          RD_WAIT_RST = 10,
  parameter int          WR_WAIT_RST = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o,
  output logic        err_irq_o
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [17:0] DEPTH_W = 18'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        csr_q, we_q;
  logic [18:2] adr_q;
  logic [3:0]  sel_q;
  logic [31:0] wdat_q, rdat_q, rd_mux;
  logic [7:0]  rd_wait_q, wr_wait_q;
  logic [15:0] errcnt_q;
  logic [31:0] mem [DEPTH];

  logic          hit, done, oor;
  logic [AW-1:0] widx;
  logic          unused_adr;

  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == BASE_ADDR);
  assign oor        = !csr_q && ({1'b0, adr_q[18:2]} >= DEPTH_W);
  assign widx       = adr_q[AW+1:2];
  assign unused_adr = ^wbs_adr_i[1:0];

  // The edge leaving WAIT with cnt exhausted is the single commit point for
  // memory writes, CSR updates, error counting and read-data capture.
  assign done = (state_q == WAIT) && (cnt_q == 8'd0) && wbs_cyc_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // WAIT always lasts latched-wait + 1 cycles, so ack lands W+1 cycles after sampling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (hit) begin
        state_d = WAIT;
        cnt_d   = wbs_we_i ? wr_wait_q : rd_wait_q;
      end
      WAIT: begin
        if (!wbs_cyc_i)           state_d = IDLE;
        else if (cnt_q == 8'd0)   state_d = ACK;
        else                      cnt_d   = cnt_q - 8'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      csr_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      sel_q  <= 4'h0;
      wdat_q <= 32'h0;
    end else if (state_q == IDLE && hit) begin
      csr_q  <= wbs_adr_i[19];
      we_q   <= wbs_we_i;
      adr_q  <= wbs_adr_i[18:2];
      sel_q  <= wbs_sel_i;
      wdat_q <= wbs_dat_i;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    if (csr_q) begin
      case (adr_q[3:2])
        2'd0:    rd_mux = {16'h0, wr_wait_q, rd_wait_q};
        2'd1:    rd_mux = {16'h0, errcnt_q};
        2'd2:    rd_mux = 32'(DEPTH);
        default: rd_mux = 32'h0;
      endcase
    end else if (!oor) begin
      rd_mux = mem[widx];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rdat_q    <= 32'h0;
      rd_wait_q <= 8'(RD_WAIT_RST);
      wr_wait_q <= 8'(WR_WAIT_RST);
      errcnt_q  <= 16'h0;
    end else if (done) begin
      rdat_q <= we_q ? 32'h0 : rd_mux;
      if (we_q && csr_q) begin
        case (adr_q[3:2])
          2'd0: begin
            if (sel_q[0]) rd_wait_q <= wdat_q[7:0];
            if (sel_q[1]) wr_wait_q <= wdat_q[15:8];
          end
          2'd1:    errcnt_q <= 16'h0;
          default: ;
        endcase
      end else if (oor && errcnt_q != 16'hFFFF) begin
        errcnt_q <= errcnt_q + 16'h1;
      end
    end
  end

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge wb_clk_i) begin
    if (done && we_q && !csr_q && !oor) begin
      for (int b = 0; b < 4; b++)
        if (sel_q[b]) mem[widx][8*b +: 8] <= wdat_q[8*b +: 8];
    end
  end

  assign wbs_ack_o = (state_q == ACK);
  assign wbs_dat_o = wbs_ack_o ? rdat_q : 32'h0;
  assign busy_o    = (state_q != IDLE);
  assign err_irq_o = wbs_ack_o && oor;

endmodule

// File: tb/tb_wb_bram_waitstate_ctrl.sv
// Bench for wb_bram_waitstate_ctrl: directed steps plus random traffic
// checked against a transaction-level model of memory, CSRs and latency.
module tb_wb_bram_waitstate_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack, busy, irq;
  logic [31:0] dat_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rd_w, wr_w;
  logic [15:0] ecnt;
  logic [31:0] mem_m [1024];
  logic [3:0]  kn    [1024];

  wb_bram_waitstate_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .busy_o(busy), .err_irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rd_w = 8'd10;
    wr_w = 8'd10;
    ecnt = 16'h0;
  endtask

  // One full transaction: predict from the model, run the bus, compare, update.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd);
    int          expw, lat, idx;
    logic        exp_irq, chk_d, got, irq_s;
    logic [31:0] exp_d;
    expw    = int'(w ? wr_w : rd_w);
    idx     = int'(a[18:2]);
    exp_irq = 1'b0;
    exp_d   = 32'h0;
    chk_d   = !w;
    if (a[19]) begin
      case (a[3:2])
        2'd0:    exp_d = {16'h0, wr_w, rd_w};
        2'd1:    exp_d = {16'h0, ecnt};
        2'd2:    exp_d = 32'd1024;
        default: exp_d = 32'h0;
      endcase
    end else if (idx >= 1024) begin
      exp_irq = 1'b1;
    end else begin
      exp_d = mem_m[idx];
      chk_d = !w && (kn[idx] == 4'hF);
    end

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    lat = -1; got = 1'b0; irq_s = 1'b0; rd = 32'h0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ack) begin
        got = 1'b1; rd = dat_o; irq_s = irq;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("ack_latency", 32'(lat), 32'(expw + 1));
      chk("err_irq", 32'(irq_s), 32'(exp_irq));
      if (chk_d) chk("rdata", rd, exp_d);
    end
    @(negedge clk);
    chk("single_ack", 32'(ack), 32'd0);

    if (a[19]) begin
      if (w && a[3:2] == 2'd0) begin
        if (s[0]) rd_w = d[7:0];
        if (s[1]) wr_w = d[15:8];
      end else if (w && a[3:2] == 2'd1) begin
        ecnt = 16'h0;
      end
    end else if (idx >= 1024) begin
      if (ecnt != 16'hFFFF) ecnt = ecnt + 16'h1;
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) begin
          mem_m[idx][8*b +: 8] = d[8*b +: 8];
          kn[idx][b] = 1'b1;
        end
    end
  endtask

  initial begin
    logic [31:0] r;
    int          k, ix;
    for (int i = 0; i < 1024; i++) begin
      kn[i] = 4'h0; mem_m[i] = 32'h0;
    end
    model_reset();
    cyc = 0; stb = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    access(1'b0, 32'h3808_0000, 4'hF, 32'h0, r);
    chk("ctrl_default", r, 32'h0000_0A0A);
    access(1'b0, 32'h3808_0008, 4'hF, 32'h0, r);
    chk("depth_csr", r, 32'd1024);

    access(1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, r);
    access(1'b0, 32'h3800_0010, 4'hF, 32'h0, r);
    chk("full_word", r, 32'hDEAD_BEEF);
    access(1'b1, 32'h3800_0010, 4'b0101, 32'h1122_3344, r);
    access(1'b0, 32'h3800_0010, 4'hF, 32'h0, r);
    chk("byte_lanes", r, 32'hDE22_BE44);
    access(1'b1, 32'h3800_0010, 4'b0000, 32'h5555_5555, r);
    access(1'b0, 32'h3800_0010, 4'hF, 32'h0, r);
    chk("sel_zero", r, 32'hDE22_BE44);

    access(1'b1, 32'h3808_0000, 4'hF, 32'h0000_0300, r);
    access(1'b0, 32'h3800_0010, 4'hF, 32'h0, r);
    access(1'b1, 32'h3800_0FFC, 4'hF, 32'hA5A5_0FFC, r);
    access(1'b0, 32'h3800_0FFC, 4'hF, 32'h0, r);
    chk("last_word", r, 32'hA5A5_0FFC);

    access(1'b0, 32'h3800_1000, 4'hF, 32'h0, r);
    chk("oor_data", r, 32'h0);
    access(1'b0, 32'h3808_0004, 4'hF, 32'h0, r);
    chk("errcnt_one", r, 32'd1);
    access(1'b1, 32'h3808_0004, 4'h0, 32'h0, r);
    access(1'b0, 32'h3808_0004, 4'hF, 32'h0, r);
    chk("errcnt_clr", r, 32'd0);

    // Abort a write by dropping cyc during WAIT (wr_wait = 3).
    access(1'b1, 32'h3800_0020, 4'hF, 32'hCAFE_F00D, r);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h3800_0020; sel = 4'hF; dat_i = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_wait", 32'(busy), 32'd1);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_no_ack", 32'(ack), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_ack_late", 32'(ack), 32'd0);
    access(1'b0, 32'h3800_0020, 4'hF, 32'h0, r);
    chk("abort_mem", r, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a write's WAIT phase.
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h3800_0010; sel = 4'hF; dat_i = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_dat", dat_o, 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    cyc = 0; stb = 0; we = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h3808_0000, 4'hF, 32'h0, r);
    chk("ctrl_after_rst", r, 32'h0000_0A0A);
    access(1'b0, 32'h3800_0010, 4'hF, 32'h0, r);
    chk("mem_kept", r, 32'hDE22_BE44);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: access(1'b1, 32'h3808_0000, 4'($urandom_range(0, 15)),
                  {16'h0, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))}, r);
        1: access(1'($urandom_range(0, 1)), 32'h3808_0000 | (32'($urandom_range(0, 3)) << 2),
                  4'($urandom_range(0, 15)), $urandom & 32'hFFFF_0707, r);
        2: access(1'b1, 32'h3808_0004, 4'($urandom_range(0, 15)), $urandom, r);
        3: begin
          ix = $urandom_range(1024, 131071);
          access(1'($urandom_range(0, 1)), 32'h3800_0000 | (32'(ix) << 2),
                 4'($urandom_range(0, 15)), $urandom, r);
        end
        default: begin
          ix = $urandom_range(0, 31);
          access(1'($urandom_range(0, 1)), 32'h3800_0000 | (32'(ix) << 2),
                 4'($urandom_range(0, 15)), $urandom, r);
        end
      endcase
    end
    access(1'b0, 32'h3808_0004, 4'hF, 32'h0, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
